// File: rtl/alu_pkg.sv
// Shared ALU definitions for the ALU-sharing arbiter.
// Holds the datapath widths and the ALU control codes understood by the
// shared combinational ALU. Codes 4'b1010..4'b1111 are undefined; the
// arbiter passes them through untouched.
package alu_pkg;

    localparam int XLEN      = 32;
    localparam int ALUCTRL_W = 4;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALUCTRL_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALUCTRL_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [ALUCTRL_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [ALUCTRL_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALUCTRL_W-1:0] ALU_SLL  = 4'b0101;
    localparam logic [ALUCTRL_W-1:0] ALU_SRL  = 4'b0110;
    localparam logic [ALUCTRL_W-1:0] ALU_SRA  = 4'b0111;
    localparam logic [ALUCTRL_W-1:0] ALU_SLT  = 4'b1000;
    localparam logic [ALUCTRL_W-1:0] ALU_SLTU = 4'b1001;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the requesters plus response consumer
// (master side) and the ALU-sharing arbiter (slave side).
//   req_valid/req_ready : per-requester handshake, one bit per requester
//   req_a/req_b/req_op  : packed operands and ALU code, slice i = requester i
//   rsp_valid/rsp_ready : one-entry response handshake
//   rsp_data/rsp_id     : captured ALU result and issuing requester index
interface alu_share_arbiter_if
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) ();

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*XLEN-1:0]      req_a;
    logic [NUM_REQ*XLEN-1:0]      req_b;
    logic [NUM_REQ*ALUCTRL_W-1:0] req_op;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [XLEN-1:0]              rsp_data;
    logic [ID_W-1:0]              rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   rr_ptr  : index that has highest priority this cycle
//   enable  : grant permitted this cycle
//   grant   : one-hot grant (all zero when disabled or nothing requested)
//   gnt     : binary index of the selected requester (valid even when
//             enable is low, so the parent can steer the operand mux)
//   any_gnt : a grant is being issued
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    gnt,
    output logic               any_gnt
);

    logic found;
    int   scan_idx;

    always_comb begin
        found    = 1'b0;
        gnt      = '0;
        scan_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Wrap modulo NUM_REQ without a divider; works for non-power-of-2 counts.
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && (scan_idx == j) && req[j]) begin
                    found = 1'b1;
                    gnt   = ID_W'(j);
                end
            end
        end
    end

    assign any_gnt = found && enable;

    always_comb begin
        grant = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            grant[j] = any_gnt && (gnt == ID_W'(j));
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters.
// Round-robin arbitration picks one valid requester per cycle, drives its
// operands onto the shared ALU and captures the result into a one-entry
// response register tagged with the requester id.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : request/response bundle (slave side)
//   alu_a/b    : operands to the shared ALU
//   alu_ctrl   : control code to the shared ALU
//   alu_result : combinational result from the shared ALU
//   grant_cnt  : accepted operations, saturating at 16'hFFFF
// ID_W must equal max(1, clog2(NUM_REQ)).
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_share_arbiter_if.slave   bus,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    input  logic [XLEN-1:0]      alu_result,
    output logic [15:0]          grant_cnt
);

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    gnt;
    logic [ID_W-1:0]    sel;
    logic [ID_W-1:0]    next_ptr;
    logic [NUM_REQ-1:0] grant;
    logic               any_gnt;
    logic               can_issue;

    logic               rsp_valid_q;
    logic [XLEN-1:0]    rsp_data_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [15:0]        grant_cnt_q;

    // Slot is free, or its current occupant leaves this cycle.
    assign can_issue = !rsp_valid_q || bus.rsp_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req     (bus.req_valid),
        .rr_ptr  (rr_ptr),
        .enable  (can_issue),
        .grant   (grant),
        .gnt     (gnt),
        .any_gnt (any_gnt)
    );

    assign bus.req_ready = grant;

    // Idle cycles steer the rr_ptr slice so the ALU inputs stay defined.
    assign sel = any_gnt ? gnt : rr_ptr;

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == ID_W'(i)) begin
                alu_a    = bus.req_a[i*XLEN +: XLEN];
                alu_b    = bus.req_b[i*XLEN +: XLEN];
                alu_ctrl = bus.req_op[i*ALUCTRL_W +: ALUCTRL_W];
            end
        end
    end

    assign next_ptr = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + ID_W'(1);

    // any_gnt already implies req_valid[gnt] && req_ready[gnt].
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            grant_cnt_q <= '0;
        end else if (any_gnt) begin
            rr_ptr      <= next_ptr;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= alu_result;
            rsp_id_q    <= gnt;
            if (grant_cnt_q != 16'hFFFF) begin
                grant_cnt_q <= grant_cnt_q + 16'd1;
            end
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign grant_cnt     = grant_cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with NUM_REQ=2.
// A behavioural ALU answers the shared ALU port. A reference model of the
// pointer, response slot and counter runs on every falling edge: it checks
// req_ready, the idle operand steering, rsp_valid and grant_cnt, pushes the
// expected response into a scoreboard queue on each accept and compares the
// response against the queue head. Directed tasks add spot checks.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int N = 2;

    typedef struct packed {
        logic [0:0]  id;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic [15:0] grant_cnt;

    logic        rv  [N];
    logic [31:0] ra  [N];
    logic [31:0] rb  [N];
    logic [3:0]  rop [N];
    logic        rsp_ready;

    int n_cmp = 0;
    int n_err = 0;

    alu_share_arbiter_if #(.NUM_REQ(N), .ID_W(1)) bus ();

    alu_share_arbiter #(.NUM_REQ(N), .ID_W(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .grant_cnt  (grant_cnt)
    );

    always #5 clk = ~clk;

    assign bus.req_valid = {rv[1], rv[0]};
    assign bus.req_a     = {ra[1], ra[0]};
    assign bus.req_b     = {rb[1], rb[0]};
    assign bus.req_op    = {rop[1], rop[0]};
    assign bus.rsp_ready = rsp_ready;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'd0, a < b};
            default:  return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_ctrl);

    // ---------------- reference model + scoreboard ----------------
    logic        mon_en  = 1'b0;
    logic        m_valid = 1'b0;
    int          m_ptr   = 0;
    logic [15:0] m_cnt   = 16'd0;
    rsp_t        sb[$];

    always @(negedge clk) begin
        if (mon_en) begin
            logic       can;
            logic       found;
            int         g;
            logic [1:0] exp_ready;
            rsp_t       e;

            n_cmp++;
            if (bus.rsp_valid !== m_valid) begin
                n_err++;
                $display("FAIL sb_rsp_valid t=%0t: got %b want %b", $time, bus.rsp_valid, m_valid);
            end
            n_cmp++;
            if (grant_cnt !== m_cnt) begin
                n_err++;
                $display("FAIL sb_grant_cnt t=%0t: got %h want %h", $time, grant_cnt, m_cnt);
            end
            if (m_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_empty t=%0t: got empty queue want one entry", $time);
                end else if (bus.rsp_data !== sb[0].data || bus.rsp_id !== sb[0].id) begin
                    n_err++;
                    $display("FAIL sb_rsp t=%0t: got id %0d data %h want id %0d data %h",
                             $time, bus.rsp_id, bus.rsp_data, sb[0].id, sb[0].data);
                end
            end

            can   = !m_valid || rsp_ready;
            found = 1'b0;
            g     = 0;
            for (int i = 0; i < N; i++) begin
                int idx;
                idx = (m_ptr + i) % N;
                if (!found && rv[idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
            exp_ready = 2'b00;
            if (can && found) exp_ready = (g == 0) ? 2'b01 : 2'b10;
            n_cmp++;
            if (bus.req_ready !== exp_ready) begin
                n_err++;
                $display("FAIL sb_req_ready t=%0t: got %b want %b", $time, bus.req_ready, exp_ready);
            end
            if (!(can && found)) begin
                n_cmp++;
                if (alu_a !== ra[m_ptr] || alu_ctrl !== rop[m_ptr]) begin
                    n_err++;
                    $display("FAIL sb_idle_mux t=%0t: got a %h op %h want a %h op %h",
                             $time, alu_a, alu_ctrl, ra[m_ptr], rop[m_ptr]);
                end
            end

            if (rst) begin
                m_valid = 1'b0;
                m_ptr   = 0;
                m_cnt   = 16'd0;
                sb.delete();
            end else if (can && found) begin
                if (m_valid && sb.size() > 0) void'(sb.pop_front());
                e.id   = 1'(g);
                e.data = alu_f(ra[g], rb[g], rop[g]);
                sb.push_back(e);
                m_valid = 1'b1;
                m_ptr   = (g + 1) % N;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else if (m_valid && rsp_ready) begin
                if (sb.size() > 0) void'(sb.pop_front());
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- directed tests ----------------
    task automatic test_reset();
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'd0 || bus.rsp_id !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rsp: got v %b d %h id %b want 0 0 0",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_id);
        end
        n_cmp++;
        if (grant_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_cnt: got %h want 0000", grant_cnt);
        end
        n_cmp++;
        if (bus.req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 00", bus.req_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        rv[1] = 1'b1; ra[1] = 32'd5; rb[1] = 32'd3; rop[1] = ALU_SUB; rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 2'b10) begin
            n_err++;
            $display("FAIL single_ready: got %b want 10", bus.req_ready);
        end
        @(posedge clk); #1;
        rv[1] = 1'b0;
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd2 || bus.rsp_id !== 1'b1
            || grant_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL single_rsp: got v %b d %h id %b cnt %0d want 1 00000002 1 1",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_id, grant_cnt);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_drain: got %b want 0", bus.rsp_valid);
        end
    endtask

    task automatic test_contention();
        rv[0] = 1'b1; ra[0] = 32'd1; rb[0] = 32'd2; rop[0] = ALU_ADD;
        rv[1] = 1'b1; ra[1] = 32'hFFFF_FFFF; rb[1] = 32'd0; rop[1] = ALU_SLT;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [1:0]  e_rdy;
            logic [31:0] e_dat;
            e_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            e_dat = (k % 2 == 0) ? 32'd3 : 32'd1;
            @(negedge clk);
            n_cmp++;
            if (bus.req_ready !== e_rdy) begin
                n_err++;
                $display("FAIL contention_ready k=%0d: got %b want %b", k, bus.req_ready, e_rdy);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'(k % 2) || bus.rsp_data !== e_dat) begin
                n_err++;
                $display("FAIL contention_rsp k=%0d: got v %b id %b d %h want 1 %0d %h",
                         k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, k % 2, e_dat);
            end
        end
        rv[0] = 1'b0; rv[1] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        rv[0] = 1'b1; ra[0] = 32'hF0F0_F0F0; rb[0] = 32'hFFFF_0000; rop[0] = ALU_XOR;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL bp_first_ready: got %b want 01", bus.req_ready);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.req_ready !== 2'b00) begin
                n_err++;
                $display("FAIL bp_ready k=%0d: got %b want 00", k, bus.req_ready);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0F0F_F0F0 || bus.rsp_id !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold k=%0d: got v %b d %h id %b want 1 0f0ff0f0 0",
                         k, bus.rsp_valid, bus.rsp_data, bus.rsp_id);
            end
        end
        rsp_ready = 1'b1; rb[0] = 32'd1; rop[0] = ALU_ADD;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL bp_release_ready: got %b want 01", bus.req_ready);
        end
        @(posedge clk); #1;
        rv[0] = 1'b0;
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hF0F0_F0F1) begin
            n_err++;
            $display("FAIL bp_release_rsp: got v %b d %h want 1 f0f0f0f1", bus.rsp_valid, bus.rsp_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough();
        logic [31:0] ta [3] = '{32'h8000_0000, 32'd1, 32'h1234_5678};
        logic [31:0] tb_ [3] = '{32'd4, 32'hFFFF_FFFF, 32'h0000_0003};
        logic [3:0]  top [3] = '{ALU_SRA, ALU_SLTU, 4'b1111};
        logic [31:0] te [3] = '{32'hF800_0000, 32'd1, 32'd0};
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rv[1] = 1'b1; ra[1] = ta[k]; rb[1] = tb_[k]; rop[1] = top[k];
            @(posedge clk); #1;
            n_cmp++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_data !== te[k]) begin
                n_err++;
                $display("FAIL passthrough k=%0d: got v %b id %b d %h want 1 1 %h",
                         k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, te[k]);
            end
        end
        rv[1] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_response();
        rv[0] = 1'b1; ra[0] = 32'd1; rb[0] = 32'd2; rop[0] = ALU_ADD; rsp_ready = 1'b0;
        @(posedge clk); #1;
        rv[0] = 1'b0;
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd3) begin
            n_err++;
            $display("FAIL rstmid_pre: got v %b d %h want 1 00000003", bus.rsp_valid, bus.rsp_data);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'd0 || bus.rsp_id !== 1'b0
            || grant_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL rstmid_post: got v %b d %h id %b cnt %h want 0 0 0 0",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_id, grant_cnt);
        end
        rv[0] = 1'b1; rv[1] = 1'b1; rop[1] = ALU_OR; ra[1] = 32'h10; rb[1] = 32'h01;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL rstmid_ptr: got %b want 01", bus.req_ready);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] g0, g1;
        repeat (65540) @(posedge clk);
        #1;
        n_cmp++;
        if (grant_cnt !== 16'hFFFF) begin
            n_err++;
            $display("FAIL sat_cnt: got %h want ffff", grant_cnt);
        end
        @(negedge clk); g0 = bus.req_ready;
        @(negedge clk); g1 = bus.req_ready;
        n_cmp++;
        if ((g0 ^ g1) !== 2'b11) begin
            n_err++;
            $display("FAIL sat_alternate: got %b then %b want alternating one-hot", g0, g1);
        end
        @(posedge clk); #1;
        rv[0] = 1'b0; rv[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b0; ra[i] = '0; rb[i] = '0; rop[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_passthrough();
        test_reset_mid_response();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (32-bit A/B, 4-bit ALUControl, 32-bit result) between NUM_REQ requesters, e.g. the integer pipe and an address-generation/CSR helper.
- Round-robin arbitration with a valid/ready handshake per requester.
- Drives the shared ALU operand/control lines and captures the result into a one-entry response register tagged with the requester id.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 1, requester id width; must equal max(1, clog2(NUM_REQ)).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NUM_REQ*32  packed operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*32  packed operand B.
- req_op  in  NUM_REQ*4  packed ALU control code.
- alu_a  out  32  to shared ALU operand A.
- alu_b  out  32  to shared ALU operand B.
- alu_ctrl  out  4  to shared ALU control.
- alu_result  in  32  from shared ALU, combinational in alu_a/alu_b/alu_ctrl.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  32  captured ALU result.
- rsp_id  out  ID_W  index of the requester that issued the operation.
- grant_cnt  out  16  total accepted operations, saturating at 16'hFFFF.

Behaviour:
- Reset (rst=1 at edge):
  - rsp_valid=0, rsp_data=0, rsp_id=0, grant_cnt=0.
  - Round-robin pointer rr_ptr=0.
  - rst overrides any in-flight handshake; a response held at reset is dropped.
- Can-issue condition: `can_issue = !rsp_valid || rsp_ready`. The slot is free, or it is being drained this cycle.
- Arbitration (combinational):
  - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first asserted index is gnt.
  - req_ready[gnt]=1 only if can_issue and any req_valid. All other req_ready bits are 0.
  - req_ready never depends on req_valid of the same requester beyond grant selection; no combinational loop through rsp_ready, other than the can_issue term.
- ALU drive:
  - When a grant is active, alu_a/alu_b/alu_ctrl carry the granted slices.
  - Otherwise they hold the rr_ptr slice. The value is don't-care, but must be deterministic, not X.
- Accept (edge with req_valid[gnt] && req_ready[gnt]):
  - rsp_data <= alu_result, rsp_id <= gnt, rsp_valid <= 1.
  - rr_ptr <= (gnt+1) mod NUM_REQ.
  - grant_cnt increments unless it is 16'hFFFF.
- Latency: exactly 1 cycle from accept edge to rsp_valid. Throughput is 1 op/cycle when rsp_ready is held high.
- Drain without new accept (rsp_valid && rsp_ready && no grant): rsp_valid <= 0. rsp_data and rsp_id hold their values.
- Backpressure (rsp_valid && !rsp_ready):
  - All req_ready=0.
  - rsp_data, rsp_id and rsp_valid stable.
  - rr_ptr unchanged.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one with no bubble; rsp_valid stays 1.
- No requests: rr_ptr holds; the pointer only advances on an accept.
- Fairness: with all requesters continuously valid, grants cycle 0,1,..,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 accepts.
- Op codes are passed through unchecked. Undefined codes (4'b1010..4'b1111) produce whatever the ALU returns (0) and are still responded to.

Decomposition:
- Shared package alu_pkg:
  - ALU control constants: ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_AND=4'b0010, ALU_OR=4'b0011, ALU_XOR=4'b0100, ALU_SLL=4'b0101, ALU_SRL=4'b0110, ALU_SRA=4'b0111, ALU_SLT=4'b1000, ALU_SLTU=4'b1001.
  - Width constants XLEN=32, ALUCTRL_W=4.
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant, binary gnt index, any_gnt.
  - Pure combinational.
- The parent holds the pointer, response register, counter, and operand mux.

Test Plan:
- Reset mid-response: rsp_valid=1, rsp_ready=0, assert rst one cycle -> next cycle rsp_valid=0, rsp_data=0, grant_cnt=0, rr_ptr=0.
- Single request: requester 1 sends A=5, B=3, op=ALU_SUB, rsp_ready=1 -> req_ready[1]=1 same cycle; next cycle rsp_valid=1, rsp_data=2, rsp_id=1, grant_cnt=1.
- Contention (NUM_REQ=2): both valid continuously; r0 ADD(1,2); r1 SLT(-1,0), i.e. A=32'hFFFFFFFF, B=0 -> responses alternate: id0 data 3, then id1 data 1, then id0 ...; one response per cycle.
- Backpressure: r0 valid with XOR(32'hF0F0_F0F0, 32'hFFFF_0000), rsp_ready=0 for 3 cycles after the first response -> rsp_data=32'h0F0F_F0F0 stable, req_ready=0 throughout; on the rsp_ready=1 edge the next op is accepted with no bubble.
- Shift/arith pass-through: r1 SRA(32'h8000_0000, 4) -> rsp_data=32'hF800_0000. SLTU(1, 32'hFFFF_FFFF) -> rsp_data=1. Undefined op 4'b1111 -> rsp_data=0 with rsp_valid=1.
- Counter saturation: force 65537 accepts -> grant_cnt stops at 16'hFFFF; arbitration unaffected.
